// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch unit and
// the instruction RAM.
interface pc_fetch_unit_if;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Gnt;
    logic        Imem_Rvalid;
    logic [31:0] Imem_Rdata;

    modport master (
        output Imem_Req,
        output Imem_Addr,
        input  Imem_Gnt,
        input  Imem_Rvalid,
        input  Imem_Rdata
    );

    modport slave (
        input  Imem_Req,
        input  Imem_Addr,
        output Imem_Gnt,
        output Imem_Rvalid,
        output Imem_Rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer: fetches the word at PC,
// presents it to decode and advances PC to the selected target on commit.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_fetch_unit_if.master        imem,
    input  logic [31:0]            PC_Next,
    input  logic                   Commit,
    input  logic                   Stall,
    output logic [31:0]            PC,
    output logic [31:0]            PC_Plus4,
    output logic [31:0]            Instr,
    output logic                   Instr_Valid,
    output logic                   Misaligned,
    output logic [31:0]            Retired_Count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_misaligned;
    logic [31:0] r_retired_count;
    logic        w_commit;
    logic        w_target_aligned;
    logic        w_req;
    logic        w_instr_valid;

    // Stall outranks Commit, and only an instruction sitting in VALID can retire.
    assign w_commit         = (r_state == S_VALID) && Commit && !Stall;
    assign w_target_aligned = (PC_Next[1:0] == 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment at the top of each always_comb keeps every
    // path assigned, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_REQ;
            S_REQ:   if (imem.Imem_Gnt)    w_next_state = S_WAIT;
            S_WAIT:  if (imem.Imem_Rvalid) w_next_state = S_VALID;
            S_VALID: if (w_commit)         w_next_state = w_target_aligned ? S_REQ : S_HALT;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_req         = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            S_REQ:   w_req         = 1'b1;
            S_VALID: w_instr_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_instr         <= NOP_INSTR;
            r_misaligned    <= 1'b0;
            r_retired_count <= 32'd0;
        end else begin
            // A late response after reset lands outside WAIT and is dropped here.
            if (r_state == S_WAIT && imem.Imem_Rvalid) begin
                r_instr <= imem.Imem_Rdata;
            end
            if (w_commit) begin
                r_instr <= NOP_INSTR;
                if (w_target_aligned) begin
                    r_pc            <= PC_Next;
                    r_retired_count <= r_retired_count + 32'd1;
                end else begin
                    r_misaligned <= 1'b1;
                end
            end
        end
    end

    assign imem.Imem_Req  = w_req;
    assign imem.Imem_Addr = r_pc;
    assign PC             = r_pc;
    assign PC_Plus4       = r_pc + 32'd4;
    assign Instr          = r_instr;
    assign Instr_Valid    = w_instr_valid;
    assign Misaligned     = r_misaligned;
    assign Retired_Count  = r_retired_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed handshake scenarios followed
// by randomized fetch/commit transactions against a transaction-level model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC_Next;
    logic        Commit;
    logic        Stall;
    logic [31:0] PC;
    logic [31:0] PC_Plus4;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Misaligned;
    logic [31:0] Retired_Count;

    pc_fetch_unit_if u_if ();

    pc_fetch_unit #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (u_if),
        .PC_Next       (PC_Next),
        .Commit        (Commit),
        .Stall         (Stall),
        .PC            (PC),
        .PC_Plus4      (PC_Plus4),
        .Instr         (Instr),
        .Instr_Valid   (Instr_Valid),
        .Misaligned    (Misaligned),
        .Retired_Count (Retired_Count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural view: what PC, count, error flag and held instruction should be.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic [31:0] m_instr;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_outputs(input string tag, input logic req, input logic valid,
                                  input logic [31:0] instr);
        check({tag, "_pc"},    PC,                  m_pc);
        check({tag, "_plus4"}, PC_Plus4,            m_pc + 32'd4);
        check({tag, "_addr"},  u_if.Imem_Addr,      m_pc);
        check({tag, "_cnt"},   Retired_Count,       m_cnt);
        check({tag, "_mis"},   {31'd0, Misaligned}, {31'd0, m_mis});
        check({tag, "_req"},   {31'd0, u_if.Imem_Req}, {31'd0, req});
        check({tag, "_valid"}, {31'd0, Instr_Valid},   {31'd0, valid});
        check({tag, "_instr"}, Instr,               instr);
    endtask

    // Entered at a negedge with the DUT requesting; ends with the word presented.
    // Commit/Stall noise during the fetch must have no architectural effect.
    task automatic fetch(input logic [31:0] data, input int gnt_delay, input int rv_delay);
        for (int i = 0; i < gnt_delay; i++) begin
            u_if.Imem_Gnt    = 1'b0;
            u_if.Imem_Rvalid = 1'($urandom_range(0, 1));
            u_if.Imem_Rdata  = $urandom;
            Commit  = 1'($urandom_range(0, 1));
            Stall   = 1'($urandom_range(0, 1));
            PC_Next = $urandom & 32'hFFFF_FFFC;
            tick();
            expect_outputs("fetch_req_hold", 1'b1, 1'b0, NOP);
        end
        u_if.Imem_Gnt    = 1'b1;
        u_if.Imem_Rvalid = 1'b0;
        Commit = 1'($urandom_range(0, 1));
        tick();
        expect_outputs("fetch_granted", 1'b0, 1'b0, NOP);
        for (int i = 0; i < rv_delay; i++) begin
            u_if.Imem_Gnt    = 1'($urandom_range(0, 1));
            u_if.Imem_Rvalid = 1'b0;
            tick();
            expect_outputs("fetch_wait", 1'b0, 1'b0, NOP);
        end
        u_if.Imem_Gnt    = 1'b0;
        u_if.Imem_Rvalid = 1'b1;
        u_if.Imem_Rdata  = data;
        tick();
        u_if.Imem_Rvalid = 1'b0;
        Commit = 1'b0;
        Stall  = 1'b0;
        m_instr = data;
        expect_outputs("fetch_valid", 1'b0, 1'b1, data);
    endtask

    // Cycles in VALID that must not retire: either stalled (Commit random) or idle.
    task automatic valid_hold(input int n);
        for (int i = 0; i < n; i++) begin
            Stall   = 1'($urandom_range(0, 1));
            Commit  = Stall ? 1'($urandom_range(0, 1)) : 1'b0;
            PC_Next = $urandom;
            tick();
            expect_outputs("valid_hold", 1'b0, 1'b1, m_instr);
        end
        Stall  = 1'b0;
        Commit = 1'b0;
    endtask

    task automatic commit_to(input logic [31:0] target);
        Stall   = 1'b0;
        Commit  = 1'b1;
        PC_Next = target;
        tick();
        Commit = 1'b0;
        if (target % 4 == 0) begin
            m_pc  = target;
            m_cnt = m_cnt + 32'd1;
            expect_outputs("commit", 1'b1, 1'b0, NOP);
        end else begin
            m_mis = 1'b1;
            expect_outputs("commit_misaligned", 1'b0, 1'b0, NOP);
        end
    endtask

    initial begin
        logic [31:0] target;
        int          kind;

        rst_n            = 1'b0;
        PC_Next          = 32'd0;
        Commit           = 1'b0;
        Stall            = 1'b0;
        u_if.Imem_Gnt    = 1'b0;
        u_if.Imem_Rvalid = 1'b0;
        u_if.Imem_Rdata  = 32'd0;
        m_pc    = RST_PC;
        m_cnt   = 32'd0;
        m_mis   = 1'b0;
        m_instr = NOP;

        repeat (2) tick();
        expect_outputs("reset", 1'b0, 1'b0, NOP);

        // First fetch at minimum latency.
        rst_n         = 1'b1;
        u_if.Imem_Gnt = 1'b1;
        tick();
        expect_outputs("cycle1_req", 1'b1, 1'b0, NOP);
        tick();
        expect_outputs("cycle2_wait", 1'b0, 1'b0, NOP);
        u_if.Imem_Gnt    = 1'b0;
        u_if.Imem_Rvalid = 1'b1;
        u_if.Imem_Rdata  = 32'h0050_0093;
        tick();
        u_if.Imem_Rvalid = 1'b0;
        m_instr = 32'h0050_0093;
        expect_outputs("cycle3_valid", 1'b0, 1'b1, 32'h0050_0093);
        check("cycle3_plus4_abs", PC_Plus4, 32'h0000_0104);

        // Stall overrides Commit.
        Stall   = 1'b1;
        Commit  = 1'b1;
        PC_Next = 32'h0000_0200;
        repeat (2) begin
            tick();
            expect_outputs("stall_over_commit", 1'b0, 1'b1, 32'h0050_0093);
        end
        Stall = 1'b0;
        tick();
        Commit = 1'b0;
        m_pc  = 32'h0000_0200;
        m_cnt = 32'd1;
        expect_outputs("commit_0x200", 1'b1, 1'b0, NOP);
        check("commit_0x200_cnt_abs", Retired_Count, 32'd1);

        // Grant backpressure, with spurious Rvalid while requesting.
        for (int i = 0; i < 4; i++) begin
            u_if.Imem_Gnt    = 1'b0;
            u_if.Imem_Rvalid = 1'($urandom_range(0, 1));
            tick();
            expect_outputs("gnt_backpressure", 1'b1, 1'b0, NOP);
        end
        u_if.Imem_Gnt    = 1'b1;
        u_if.Imem_Rvalid = 1'b0;
        tick();
        expect_outputs("gnt_enters_wait", 1'b0, 1'b0, NOP);
        u_if.Imem_Gnt = 1'b0;
        repeat (2) begin
            tick();
            expect_outputs("wait_no_rvalid", 1'b0, 1'b0, NOP);
        end
        u_if.Imem_Rvalid = 1'b1;
        u_if.Imem_Rdata  = 32'hDEAD_BEEF;
        tick();
        u_if.Imem_Rvalid = 1'b0;
        m_instr = 32'hDEAD_BEEF;
        expect_outputs("late_response", 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Randomized commit/fetch traffic, including self-loops and the PC wrap.
        for (int t = 0; t < 40; t++) begin
            valid_hold($urandom_range(0, 3));
            kind = $urandom_range(0, 5);
            if (kind == 0)      target = m_pc;
            else if (kind == 1) target = 32'hFFFF_FFFC;
            else                target = $urandom & 32'hFFFF_FFFC;
            commit_to(target);
            if (target == 32'hFFFF_FFFC) check("pc_plus4_wrap", PC_Plus4, 32'h0000_0000);
            fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Misaligned target halts the unit until reset.
        valid_hold(1);
        commit_to(m_pc + 32'h0000_0002);
        for (int i = 0; i < 5; i++) begin
            u_if.Imem_Gnt    = 1'($urandom_range(0, 1));
            u_if.Imem_Rvalid = 1'($urandom_range(0, 1));
            u_if.Imem_Rdata  = $urandom;
            Commit  = 1'($urandom_range(0, 1));
            Stall   = 1'($urandom_range(0, 1));
            PC_Next = $urandom & 32'hFFFF_FFFC;
            tick();
            expect_outputs("halt", 1'b0, 1'b0, NOP);
        end
        check("halt_misaligned_abs", {31'd0, Misaligned}, 32'd1);
        u_if.Imem_Gnt    = 1'b0;
        u_if.Imem_Rvalid = 1'b0;
        Commit = 1'b0;
        Stall  = 1'b0;
        rst_n  = 1'b0;
        tick();
        m_pc  = RST_PC;
        m_cnt = 32'd0;
        m_mis = 1'b0;
        expect_outputs("halt_reset", 1'b0, 1'b0, NOP);

        // Reset while waiting for a response; the response arrives during reset.
        rst_n         = 1'b1;
        u_if.Imem_Gnt = 1'b1;
        tick();
        expect_outputs("midfetch_req", 1'b1, 1'b0, NOP);
        tick();
        expect_outputs("midfetch_wait", 1'b0, 1'b0, NOP);
        u_if.Imem_Gnt    = 1'b0;
        rst_n            = 1'b0;
        u_if.Imem_Rvalid = 1'b1;
        u_if.Imem_Rdata  = 32'h0BAD_0BAD;
        tick();
        expect_outputs("midfetch_in_reset", 1'b0, 1'b0, NOP);
        rst_n = 1'b1;
        tick();
        expect_outputs("midfetch_refetch_req", 1'b1, 1'b0, NOP);
        u_if.Imem_Rvalid = 1'b0;
        fetch(32'h1234_5678, 1, 0);
        commit_to(32'h0000_0040);
        fetch(32'h00A0_0113, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
